// File: rtl/vga_pixel_output.sv
// vga_pixel_output: VGA raster timing generator and DAC pin driver.
// Produces pixelX/pixelY for the drawing pipeline, takes the objects mux
// colour back PIPE_DELAY cycles later and drives sync, blanking and the
// 4-bit RGB channels, all aligned to the same pin cycle.
// Optional feature: define VGA_TEST_PATTERN_EN to replace RGBIn with an
// internally generated 8-bar colour pattern (same latency).
module vga_pixel_output #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } align_t;

  localparam align_t ALIGN_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1};

  logic [10:0] hCount;
  logic [10:0] vCount;
  logic        active0;
  logic        hs0;
  logic        vs0;
  align_t      alignPipe [PIPE_DELAY];
  align_t      alignOut;
  logic [7:0]  colourSel;
  logic [7:0]  rgbReg;

  assign pixelX = hCount;
  assign pixelY = vCount;

  // Raster counters and frame-start strobe; the strobe is registered on the
  // same edge that wraps both counters to (0,0).
  always_ff @(posedge clk) begin
    if (!resetN) begin
      hCount       <= '0;
      vCount       <= '0;
      startOfFrame <= 1'b0;
    end else begin
      startOfFrame <= (hCount == H_LAST) && (vCount == V_LAST);
      if (hCount == H_LAST) begin
        hCount <= '0;
        vCount <= (vCount == V_LAST) ? '0 : vCount + 11'd1;
      end else begin
        hCount <= hCount + 11'd1;
      end
    end
  end

  // Stage-0 decode of visible area and sync windows from the live counters.
  always_comb begin
    active0 = (hCount < H_ACT_END) && (vCount < V_ACT_END);
    hs0     = !((hCount >= HS_START) && (hCount < HS_END));
    vs0     = !((vCount >= VS_START) && (vCount < VS_END));
  end

  // Delay line matching the drawer/mux latency; reset fills it with idle
  // values so no partial sync pulse survives an abandoned frame.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
        alignPipe[i] <= ALIGN_IDLE;
      end
    end else begin
      alignPipe[0] <= '{act: active0, hs: hs0, vs: vs0};
      for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
        alignPipe[i] <= alignPipe[i-1];
      end
    end
  end

  assign alignOut = alignPipe[PIPE_DELAY-1];

`ifdef VGA_TEST_PATTERN_EN
  logic [7:0] bar0;
  logic [7:0] barPipe [PIPE_DELAY];
  logic [7:0] unusedRgbIn;

  assign unusedRgbIn = RGBIn;

  // Colour-bar value: one bar per 64 pixels, bits select R, G and B fields.
  always_comb begin
    bar0 = (hCount[8] ? 8'hE0 : 8'h00)
         | (hCount[7] ? 8'h1C : 8'h00)
         | (hCount[6] ? 8'h03 : 8'h00);
  end

  // Bar value travels alongside the decode so it lands on the same pixel.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int unsigned i = 0; i < PIPE_DELAY; i++) begin
        barPipe[i] <= '0;
      end
    end else begin
      barPipe[0] <= bar0;
      for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
        barPipe[i] <= barPipe[i-1];
      end
    end
  end

  assign colourSel = barPipe[PIPE_DELAY-1];
`else
  assign colourSel = RGBIn;
`endif

  // Pin register: sync/blank from the delayed decode, colour forced to zero
  // outside the visible area.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      hSync  <= 1'b1;
      vSync  <= 1'b1;
      blankN <= 1'b0;
      rgbReg <= '0;
    end else begin
      hSync  <= alignOut.hs;
      vSync  <= alignOut.vs;
      blankN <= alignOut.act;
      rgbReg <= alignOut.act ? colourSel : '0;
    end
  end

  // 3/3/2-bit colour widened to 4 bits by replicating the top bits.
  assign red   = {rgbReg[7:5], rgbReg[7]};
  assign green = {rgbReg[4:2], rgbReg[4]};
  assign blue  = {rgbReg[1:0], rgbReg[1:0]};

endmodule

// File: tb/tb_vga_pixel_output.sv
// tb_vga_pixel_output: two instances run side by side -- standard 640x480
// timing with PIPE_DELAY=1, and a shrunken raster with PIPE_DELAY=3 so that
// whole frames fit in a short run. A reference raster model per instance
// pushes expected pin values into a queue as stimulus is driven; they are
// popped and compared one cycle later. A colour table and run-length
// measurements of the sync/blank pulses add independent checks.
module tb_vga_pixel_output;

  localparam int MODE_ZERO  = 0;
  localparam int MODE_SPOT  = 1;
  localparam int MODE_TABLE = 2;
  localparam int MODE_FF    = 3;
  localparam int MODE_RAND  = 4;

  typedef struct packed {
    logic        v;
    logic [10:0] x;
    logic [10:0] y;
    logic        act;
    logic        hs;
    logic        vs;
  } dec_t;

  typedef struct {
    logic [7:0] rgb;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vec_t;

  // Per-instance raster parameters: [0] standard, [1] shrunken.
  int unsigned HA[2]  = '{640, 16};
  int unsigned HFP[2] = '{16, 2};
  int unsigned HSW[2] = '{96, 4};
  int unsigned HBP[2] = '{48, 3};
  int unsigned VA[2]  = '{480, 8};
  int unsigned VFP[2] = '{10, 1};
  int unsigned VSW[2] = '{2, 2};
  int unsigned VBP[2] = '{33, 2};
  int unsigned PD[2]  = '{1, 3};

  logic        clk;
  logic        resetN;
  logic [7:0]  rgbA, rgbB;
  logic [10:0] xA, yA, xB, yB;
  logic        sofA, hsA, vsA, bkA, sofB, hsB, vsB, bkB;
  logic [3:0]  rA, gA, bA, rB, gB, bB;

  vga_pixel_output #(.PIPE_DELAY(1)) dutA (
    .clk(clk), .resetN(resetN), .RGBIn(rgbA),
    .pixelX(xA), .pixelY(yA), .startOfFrame(sofA),
    .hSync(hsA), .vSync(vsA), .blankN(bkA),
    .red(rA), .green(gA), .blue(bA)
  );

  vga_pixel_output #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .PIPE_DELAY(3)
  ) dutB (
    .clk(clk), .resetN(resetN), .RGBIn(rgbB),
    .pixelX(xB), .pixelY(yB), .startOfFrame(sofB),
    .hSync(hsB), .vSync(vsB), .blankN(bkB),
    .red(rB), .green(gB), .blue(bB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          nChecks = 0;
  int          nErr = 0;
  int          mode = MODE_ZERO;
  bit          sbOn = 0;
  bit          countSpot = 0;
  bit          ffWatch = 0;
  int unsigned ti = 0;

  dec_t        dq[2][$];
  logic [14:0] eq[2][$];
  int unsigned mh[2], mv[2], crel[2];
  logic        esof[2];
  int unsigned nsof[2];
  int unsigned spotSeen[2];
  int unsigned ffViol[2];
  logic        hsPrev[2], vsPrev[2], bkPrev[2];
  bit          hsArm[2], vsArm[2], bkArm[2];
  int unsigned hsRun[2], vsRun[2], bkRun[2];
  vec_t        tbl[8];

  function automatic int unsigned htot(input int i);
    return HA[i] + HFP[i] + HSW[i] + HBP[i];
  endfunction

  function automatic int unsigned vtot(input int i);
    return VA[i] + VFP[i] + VSW[i] + VBP[i];
  endfunction

  function automatic logic [11:0] expand(input logic [7:0] c);
    return {c[7], c[6], c[5], c[7], c[4], c[3], c[2], c[4], c[1], c[0], c[1], c[0]};
  endfunction

  function automatic logic [7:0] bar(input logic [10:0] x);
    logic [7:0] c;
    c = 8'h00;
    if (x[8]) c = c | 8'hE0;
    if (x[7]) c = c | 8'h1C;
    if (x[6]) c = c | 8'h03;
    return c;
  endfunction

  function automatic dec_t decode(input int i, input int unsigned x, input int unsigned y);
    dec_t d;
    d.v   = 1'b1;
    d.x   = 11'(x);
    d.y   = 11'(y);
    d.act = (x < HA[i]) && (y < VA[i]);
    d.hs  = !((x >= HA[i] + HFP[i]) && (x < HA[i] + HFP[i] + HSW[i]));
    d.vs  = !((y >= VA[i] + VFP[i]) && (y < VA[i] + VFP[i] + VSW[i]));
    return d;
  endfunction

  function automatic logic [14:0] pinsOf(input int i);
    if (i == 0) return {hsA, vsA, bkA, rA, gA, bA};
    return {hsB, vsB, bkB, rB, gB, bB};
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s inst%0d cycle %0d: got 0x%0h expected 0x%0h", name, i, crel[i], act, exp);
    end
  endtask

  task automatic check_inst(input int i);
    logic [14:0] p;
    logic [21:0] xy;
    logic        sof;
    int unsigned ht, hv;
    ht  = htot(i);
    hv  = ht * vtot(i);
    p   = pinsOf(i);
    xy  = (i == 0) ? {xA, yA} : {xB, yB};
    sof = (i == 0) ? sofA : sofB;

    chk("pixel_xy", i, 32'(xy), 32'({11'(mh[i]), 11'(mv[i])}));
    chk("start_of_frame", i, 32'(sof), 32'(esof[i]));
    chk("pins", i, 32'(p), 32'(eq[i].pop_front()));

    if (sof) begin
      chk("sof_cycle", i, crel[i], (nsof[i] + 1) * hv);
      nsof[i]++;
    end

    if (countSpot && p[12] && p[11:0] == 12'hF00) spotSeen[i]++;
    if (ffWatch && (p[11:0] != (p[12] ? 12'hFFF : 12'h000))) ffViol[i]++;

    // hSync low pulse: start position within the line and width
    if (!p[14]) begin
      if (hsPrev[i]) begin
        hsArm[i] = 1;
        hsRun[i] = 0;
        chk("hsync_start", i, crel[i] % ht, HA[i] + HFP[i] + PD[i] + 1);
      end
      hsRun[i]++;
    end else if (!hsPrev[i] && hsArm[i]) begin
      chk("hsync_width", i, hsRun[i], HSW[i]);
    end
    hsPrev[i] = p[14];

    // vSync low pulse
    if (!p[13]) begin
      if (vsPrev[i]) begin
        vsArm[i] = 1;
        vsRun[i] = 0;
        chk("vsync_start", i, crel[i] % hv, (VA[i] + VFP[i]) * ht + PD[i] + 1);
      end
      vsRun[i]++;
    end else if (!vsPrev[i] && vsArm[i]) begin
      chk("vsync_width", i, vsRun[i], VSW[i] * ht);
    end
    vsPrev[i] = p[13];

    // blankN high window per visible line
    if (p[12]) begin
      if (!bkPrev[i]) begin
        bkArm[i] = 1;
        bkRun[i] = 0;
        chk("blank_start", i, crel[i] % ht, PD[i] + 1);
      end
      bkRun[i]++;
    end else if (bkPrev[i] && bkArm[i]) begin
      chk("blank_width", i, bkRun[i], HA[i]);
    end
    bkPrev[i] = p[12];
  endtask

  task automatic drive_inst(input int i, input logic rn);
    dec_t        d;
    logic [7:0]  c;
    logic [11:0] e;
    if (!rn) begin
      dq[i].delete();
      eq[i].delete();
      for (int k = 0; k < int'(PD[i]); k++) dq[i].push_back('{v: 1'b0, x: '0, y: '0, act: 1'b0, hs: 1'b1, vs: 1'b1});
      eq[i].push_back({1'b1, 1'b1, 1'b0, 12'h000});
      mh[i] = 0; mv[i] = 0; crel[i] = 0; esof[i] = 1'b0; nsof[i] = 0;
      hsPrev[i] = 1'b1; vsPrev[i] = 1'b1; bkPrev[i] = 1'b0;
      hsArm[i] = 0; vsArm[i] = 0; bkArm[i] = 0;
      c = 8'($urandom);
    end else begin
      dq[i].push_back(decode(i, mh[i], mv[i]));
      d = dq[i].pop_front();
      c = 8'h00;
      case (mode)
        MODE_SPOT:  if (d.v && d.x == 11'd10 && d.y == 11'd5) c = 8'hE0;
        MODE_FF:    c = 8'hFF;
        MODE_RAND:  c = 8'($urandom);
        default:    c = 8'h00;
      endcase
      e = expand(c);
      if (mode == MODE_TABLE && i == 0 && d.act && ti < 8) begin
        c = tbl[ti].rgb;
        e = {tbl[ti].r, tbl[ti].g, tbl[ti].b};
        ti++;
      end
`ifdef VGA_TEST_PATTERN_EN
      e = expand(bar(d.x));
`endif
      eq[i].push_back({d.hs, d.vs, d.act, d.act ? e : 12'h000});
      esof[i] = (mh[i] == htot(i) - 1) && (mv[i] == vtot(i) - 1);
      if (mh[i] == htot(i) - 1) begin
        mh[i] = 0;
        mv[i] = (mv[i] == vtot(i) - 1) ? 0 : mv[i] + 1;
      end else begin
        mh[i] = mh[i] + 1;
      end
      crel[i]++;
    end
    if (i == 0) rgbA = c;
    else        rgbB = c;
  endtask

  task automatic step(input logic rn);
    @(negedge clk);
    if (sbOn) for (int i = 0; i < 2; i++) check_inst(i);
    resetN = rn;
    for (int i = 0; i < 2; i++) drive_inst(i, rn);
    sbOn = 1;
  endtask

  initial begin
    tbl[0] = '{rgb: 8'hFF, r: 4'hF, g: 4'hF, b: 4'hF};
    tbl[1] = '{rgb: 8'hE0, r: 4'hF, g: 4'h0, b: 4'h0};
    tbl[2] = '{rgb: 8'h03, r: 4'h0, g: 4'h0, b: 4'hF};
    tbl[3] = '{rgb: 8'h00, r: 4'h0, g: 4'h0, b: 4'h0};
    tbl[4] = '{rgb: 8'h1C, r: 4'h0, g: 4'hF, b: 4'h0};
    tbl[5] = '{rgb: 8'hA5, r: 4'hB, g: 4'h2, b: 4'h5};
    tbl[6] = '{rgb: 8'h6A, r: 4'h6, g: 4'h4, b: 4'hA};
    tbl[7] = '{rgb: 8'h49, r: 4'h4, g: 4'h4, b: 4'h5};

    resetN = 1'b0;
    rgbA = 8'h00;
    rgbB = 8'h00;
    for (int i = 0; i < 2; i++) begin
      spotSeen[i] = 0;
      ffViol[i] = 0;
    end

    repeat (3) step(1'b0);
    repeat (1000) step(1'b1);
    // mid-frame reset, held for 5 edges
    repeat (5) step(1'b0);

    mode = MODE_SPOT;
    countSpot = 1;
    repeat (4200) step(1'b1);
    mode = MODE_ZERO;
    repeat (10) step(1'b1);
    countSpot = 0;
`ifndef VGA_TEST_PATTERN_EN
    chk("spot_count", 0, spotSeen[0], 1);
    chk("spot_count", 1, spotSeen[1], 13);
`endif

    mode = MODE_TABLE;
    repeat (20) step(1'b1);
    chk("table_consumed", 0, ti, 8);

    mode = MODE_FF;
    repeat (5) step(1'b1);
    ffWatch = 1;
    repeat (1700) step(1'b1);
    ffWatch = 0;
`ifndef VGA_TEST_PATTERN_EN
    chk("blank_forcing", 0, ffViol[0], 0);
    chk("blank_forcing", 1, ffViol[1], 0);
`endif

    mode = MODE_RAND;
    repeat (900) step(1'b1);
    mode = MODE_ZERO;
    repeat (10) step(1'b1);

    for (int i = 0; i < 2; i++) begin
      chk("sof_count", i, nsof[i], (crel[i] - 1) / (htot(i) * vtot(i)));
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule

// File: doc/vga_pixel_output.md
# vga_pixel_output

Display-side end of the drawing pipeline. Generates VGA raster timing and the pixel coordinates that every object drawer and the objects mux consume. Takes the mux's registered 8-bit RRRGGGBB colour back and drives the DAC pins. Delays sync and blanking so they line up with the colour that arrives after the drawer and mux pipeline latency.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 1, cycles from pixelX/pixelY to a valid RGBIn; legal range 1..4

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  pixel clock
- resetN  in  1  synchronous active-low reset
- RGBIn  in  8  colour from objects mux, {R[7:5],G[4:2],B[1:0]}
- pixelX  out  11  current horizontal count
- pixelY  out  11  current vertical count
- startOfFrame  out  1  one-cycle frame-start strobe, aligned with pixelX/pixelY
- hSync  out  1  active-low horizontal sync, pin-aligned
- vSync  out  1  active-low vertical sync, pin-aligned
- blankN  out  1  high while the pin-aligned pixel is visible
- red, green, blue  out  4 each  DAC channels

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525.
- Counters:
  - hCount increments every cycle and wraps H_TOTAL-1 -> 0.
  - vCount increments on the hCount wrap and wraps V_TOTAL-1 -> 0.
  - pixelX = hCount and pixelY = vCount, driven from the registers with no extra stage.
- Stage-0 decode:
  - active = (hCount < H_ACTIVE) && (vCount < V_ACTIVE)
  - hs0 = 0 when H_ACTIVE+H_FP <= hCount < H_ACTIVE+H_FP+H_SYNC
  - vs0 = 0 when V_ACTIVE+V_FP <= vCount < V_ACTIVE+V_FP+V_SYNC
- Alignment shift register: PIPE_DELAY stages carry {active, hs0, vs0}.
- Output register stage, fed from the last shift stage:
  - hSync, vSync and blankN take the delayed decode values.
  - RGB takes RGBIn when delayed active = 1, otherwise all-zero.
- Colour expansion:
  - red = {R2,R1,R0,R2}
  - green = {G2,G1,G0,G2}
  - blue = {B1,B0,B1,B0}
  - Examples: 0xFF -> F/F/F; 0xE0 -> F/0/0; 0x03 -> 0/0/F; 0x00 -> 0/0/0.
- startOfFrame:
  - Registered; high for exactly the one cycle in which pixelX = 0 and pixelY = 0 following a frame wrap.
  - The first frame after reset release produces no strobe; the first strobe arrives H_TOTAL*V_TOTAL cycles after release.
- RGBIn is sampled every cycle. Its value is ignored, and the pins forced to 0, whenever the delayed active is low.

## Timing
- Reset (resetN = 0 at a clk edge) takes effect on that edge:
  - hCount = vCount = 0; pixelX = pixelY = 0
  - startOfFrame = 0, hSync = 1, vSync = 1, blankN = 0, red/green/blue = 0
  - every alignment stage loaded with {active = 0, hs = 1, vs = 1}
- Reset asserted mid-frame abandons the frame immediately; no partial sync pulse is extended.
- First cycle after release: pixelX = 0, pixelY = 0. Counting starts on the next edge.
- Latency: the colour for coordinate (X,Y) reaches the pins PIPE_DELAY+1 cycles after pixelX/pixelY show (X,Y). hSync, vSync and blankN have the same latency.
- hSync is low for exactly H_SYNC = 96 consecutive cycles per line. vSync is low for exactly V_SYNC*H_TOTAL = 1600 cycles per frame.
- Simultaneous hCount and vCount wrap at (799,524) -> (0,0) in a single edge, and startOfFrame rises on that same edge.

## Configuration
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - RGBIn is ignored.
  - A colour-bar value is computed at stage 0: idx = hCount[8:6]; colour = (idx[2]?0xE0:0) | (idx[1]?0x1C:0) | (idx[0]?0x03:0).
  - The bar value travels through its own PIPE_DELAY-deep 8-bit shift register and then goes through the normal blanking and expansion path.
  - Latency is unchanged.
- Undefined: no pattern logic or extra registers exist, and RGBIn is used.

## Test plan
- Reset values: hold resetN = 0 for 5 cycles mid-frame, then release.
  - During reset: outputs match the Timing reset values.
  - After release: pixelX = 0 and pixelY = 0, then pixelX counts 1, 2, 3 on successive cycles.
- Line timing: run 3 lines with PIPE_DELAY = 1.
  - hSync low for 96 cycles, starting PIPE_DELAY+1 = 2 cycles after pixelX = 656.
  - Line period 800 cycles; blankN high for 640 cycles per line.
- Frame timing: run 2 full frames.
  - vSync low for 1600 cycles starting at line 490 (pin-aligned).
  - First startOfFrame at cycle 420000 after release, second at 840000, each one cycle wide.
- Colour latency: drive RGBIn = 0xE0 only in the cycle PIPE_DELAY after pixelX = 10 and pixelY = 5, 0x00 otherwise.
  - Pins show red = F, green = 0, blue = 0 for exactly one cycle, PIPE_DELAY+1 cycles after pixelX = 10.
  - Repeat with PIPE_DELAY = 3.
- Blank forcing: drive RGBIn = 0xFF constantly.
  - red/green/blue = 0 whenever blankN = 0; F/F/F whenever blankN = 1.
- With VGA_TEST_PATTERN_EN: line 0 pins show 0x000 for pixels 0-63, blue F for 64-127, green F for 128-191, and white for 448-511.
